regfile_write_queue: RTL and testbench

- Buffers pending register-file writes from the write-back stage and drains them, one per cycle, onto the register file write port.
- Sits directly upstream of the 5-to-32 write-select decoder: wr_reg drives the decoder's 5-bit select input, and wr_enable gates the decoded one-hot line.
- Reports read-after-write hazards for two read ports so the pipeline can stall on registers whose writes are still queued.

---
 rtl/regfile_write_queue.sv | 115 +++++++++++
 tb/tb_regfile_write_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Register-file write queue: buffers write-back writes, drains one per cycle, flags RAW hazards.
// Optional macro WQ_FORWARD_EN adds youngest-match forwarding ports for both read ports.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          wr_stall,
    output logic          wr_enable,
    output logic [4:0]    wr_reg,
    output logic [31:0]   wr_data,
    input  logic [4:0]    rd_reg_a,
    input  logic [4:0]    rd_reg_b,
    output logic          hazard_a,
    output logic          hazard_b,
`ifdef WQ_FORWARD_EN
    output logic          fwd_valid_a,
    output logic          fwd_valid_b,
    output logic [31:0]   fwd_data_a,
    output logic [31:0]   fwd_data_b,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    reg_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;

    assign in_ready  = (count_q != FULL);
    assign wr_enable = (count_q != '0) && !wr_stall;
    // Writes to r0 complete the handshake but are dropped, since r0 is never written.
    assign push      = in_valid && in_ready && (in_reg != 5'd0);
    assign pop       = wr_enable;

    assign wr_reg  = (count_q != '0) ? reg_q[head_q]  : 5'd0;
    assign wr_data = (count_q != '0) ? data_q[head_q] : 32'd0;
    assign count   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: entries are cleared too so no stale data is visible after reset.
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                reg_q[tail_q]  <= in_reg;
                data_q[tail_q] <= in_data;
            end
        end
    end

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_scan
        logic [AW-1:0] offset;
        assign offset      = AW'(i) - head_q;
        assign occupied[i] = ({1'b0, offset} < count_q);
        assign match_a[i]  = occupied[i] && (reg_q[i] == rd_reg_a) && (rd_reg_a != 5'd0);
        assign match_b[i]  = occupied[i] && (reg_q[i] == rd_reg_b) && (rd_reg_b != 5'd0);
    end

    assign hazard_a = |match_a;
    assign hazard_b = |match_b;

`ifdef WQ_FORWARD_EN
    assign fwd_valid_a = hazard_a;
    assign fwd_valid_b = hazard_b;

    // Walk from head toward tail so the youngest matching entry wins.
    always_comb begin
        fwd_data_a = 32'd0;
        fwd_data_b = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_a[head_q + AW'(k)]) fwd_data_a = data_q[head_q + AW'(k)];
            if (match_b[head_q + AW'(k)]) fwd_data_b = data_q[head_q + AW'(k)];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue (DEPTH=4); forwarding checks run when WQ_FORWARD_EN is defined.
module tb_regfile_write_queue;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wr_stall;
    logic        wr_enable;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rd_reg_a;
    logic [4:0]  rd_reg_b;
    logic        hazard_a;
    logic        hazard_b;
    logic [2:0]  count;
`ifdef WQ_FORWARD_EN
    logic        fwd_valid_a;
    logic        fwd_valid_b;
    logic [31:0] fwd_data_a;
    logic [31:0] fwd_data_b;
`endif

    int total = 0;
    int bad   = 0;

    regfile_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_reg    (in_reg),
        .in_data   (in_data),
        .wr_stall  (wr_stall),
        .wr_enable (wr_enable),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_a  (rd_reg_a),
        .rd_reg_b  (rd_reg_b),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
`ifdef WQ_FORWARD_EN
        .fwd_valid_a (fwd_valid_a),
        .fwd_valid_b (fwd_valid_b),
        .fwd_data_a  (fwd_data_a),
        .fwd_data_b  (fwd_data_b),
`endif
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_reg   = 5'd0;
        in_data  = 32'd0;
        wr_stall = 1'b0;
        rd_reg_a = 5'd0;
        rd_reg_b = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_count",    32'(count),     32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_wr_en",    32'(wr_enable), 32'd0);
        check("rst_wr_reg",   32'(wr_reg),    32'd0);
        check("rst_wr_data",  wr_data,        32'd0);
        check("rst_haz_a",    32'(hazard_a),  32'd0);
        check("rst_haz_b",    32'(hazard_b),  32'd0);

        // Single write: no fall-through, visible the next cycle, drained after that.
        in_valid = 1'b1;
        in_reg   = 5'd5;
        in_data  = 32'hDEADBEEF;
        #1;
        check("single_no_fallthru", 32'(wr_enable), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check("single_wr_en",   32'(wr_enable), 32'd1);
        check("single_wr_reg",  32'(wr_reg),    32'd5);
        check("single_wr_data", wr_data,        32'hDEADBEEF);
        check("single_count",   32'(count),     32'd1);
        tick();
        check("single_drained", 32'(count),     32'd0);
        check("single_wr_en0",  32'(wr_enable), 32'd0);

        // Fill under stall, refuse a fifth push, then drain in order.
        wr_stall = 1'b1;
        for (int r = 1; r <= 4; r++) push_one(5'(r), 32'h100 * r);
        check("full_count",    32'(count),     32'd4);
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_wr_en",    32'(wr_enable), 32'd0);
        check("full_head_reg", 32'(wr_reg),    32'd1);
        push_one(5'd8, 32'h800);
        check("refused_count", 32'(count),     32'd4);
        wr_stall = 1'b0;
        #1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_wr_en",   32'(wr_enable), 32'd1);
            check("drain_wr_reg",  32'(wr_reg),    32'(k));
            check("drain_wr_data", wr_data,        32'h100 * k);
            tick();
        end
        check("drain_empty", 32'(count), 32'd0);

        // Write to r0: handshake completes, nothing stored.
        in_valid = 1'b1;
        in_reg   = 5'd0;
        in_data  = 32'h1234;
        #1;
        check("r0_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("r0_count", 32'(count),     32'd0);
        check("r0_wr_en", 32'(wr_enable), 32'd0);
        tick();
        check("r0_wr_en_late", 32'(wr_enable), 32'd0);

        // Hazards against queued entries.
        wr_stall = 1'b1;
        push_one(5'd7, 32'h70);
        push_one(5'd9, 32'h90);
        rd_reg_a = 5'd9;
        rd_reg_b = 5'd0;
        #1;
        check("haz_a_match", 32'(hazard_a), 32'd1);
        check("haz_b_r0",    32'(hazard_b), 32'd0);
        rd_reg_b = 5'd7;
        #1;
        check("haz_b_head", 32'(hazard_b), 32'd1);
        rd_reg_b = 5'd3;
        #1;
        check("haz_b_miss", 32'(hazard_b), 32'd0);
        wr_stall = 1'b0;
        tick();
        check("haz_a_popping_head", 32'(hazard_a), 32'd1);
        check("haz_popping_en",     32'(wr_enable), 32'd1);
        tick();
        check("haz_drained_count", 32'(count),    32'd0);
        check("haz_a_drained",     32'(hazard_a), 32'd0);

        // Full queue with pop and push offered together, then push+pop across the wrap.
        wr_stall = 1'b1;
        for (int r = 1; r <= 4; r++) push_one(5'(r), 32'hA0 + r);
        wr_stall = 1'b0;
        in_valid = 1'b1;
        in_reg   = 5'd10;
        in_data  = 32'hA;
        #1;
        check("fullpop_ready", 32'(in_ready),  32'd0);
        check("fullpop_wr_en", 32'(wr_enable), 32'd1);
        tick();
        check("fullpop_count", 32'(count),  32'd3);
        check("fullpop_head",  32'(wr_reg), 32'd2);
        in_reg  = 5'd11;
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        #1;
        check("pushpop_count", 32'(count),  32'd3);
        check("pushpop_head",  32'(wr_reg), 32'd3);
        check("wrap_reg_3",  32'(wr_reg), 32'd3);
        check("wrap_data_3", wr_data,     32'hA3);
        tick();
        check("wrap_reg_4",  32'(wr_reg), 32'd4);
        check("wrap_data_4", wr_data,     32'hA4);
        tick();
        check("wrap_reg_11",  32'(wr_reg), 32'd11);
        check("wrap_data_11", wr_data,     32'hB);
        tick();
        check("wrap_empty", 32'(count), 32'd0);

        // Reset mid-operation wins over a concurrent push.
        wr_stall = 1'b1;
        push_one(5'd20, 32'h20);
        push_one(5'd21, 32'h21);
        push_one(5'd22, 32'h22);
        rd_reg_a = 5'd21;
        #1;
        check("pre_rst_count", 32'(count),    32'd3);
        check("pre_rst_haz_a", 32'(hazard_a), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_reg   = 5'd23;
        in_data  = 32'h23;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        wr_stall = 1'b0;
        #1;
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_wr_en", 32'(wr_enable), 32'd0);
        check("mid_rst_haz_a", 32'(hazard_a),  32'd0);
        check("mid_rst_wr_reg", 32'(wr_reg),   32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);

`ifdef WQ_FORWARD_EN
        wr_stall = 1'b1;
        push_one(5'd6, 32'h11);
        push_one(5'd6, 32'h22);
        rd_reg_a = 5'd6;
        rd_reg_b = 5'd0;
        #1;
        check("fwd_valid_a", 32'(fwd_valid_a), 32'd1);
        check("fwd_data_a",  fwd_data_a,       32'h22);
        check("fwd_valid_b", 32'(fwd_valid_b), 32'd0);
        check("fwd_data_b",  fwd_data_b,       32'd0);
        wr_stall = 1'b0;
        tick();
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
